oflow_value_not_valid: RTL and testbench

Single-clock FIFO with a parameter-selected overflow policy, configuration validation and overflow/underflow accounting. It is the write-side guard used where a producer may push into a full FIFO. Invalid policy strings are reported on a status output rather than failing elaboration. Data is show-ahead: the head entry is visible on `rdata` whenever the FIFO is not empty.

---
 rtl/oflow_value_not_valid.sv | 98 +++++++++
 tb/tb_oflow_value_not_valid.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/oflow_value_not_valid.sv
// Single-clock show-ahead FIFO with a selectable full-push policy ("REPLACE"/"IGNORE"),
// static policy validation and overflow/underflow tracking. Define OFLOW_VALUE_NOT_VALID_STATS_EN for event counters.
module oflow_value_not_valid #(
    parameter string OFLOW = "REPLACE",
    parameter int    WIDTH = 8,
    parameter int    DEPTH = 4,
    parameter int    CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wdata,
    input  logic             wstore,
    input  logic             rread,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic [DEPTH-1:0] level,
    output logic             oflow_err,
    output logic             cfg_err,
    output logic [CNTW-1:0]  oflow_cnt,
    output logic [CNTW-1:0]  uflow_cnt
);

    localparam int NELEM       = 1 << DEPTH;
    localparam bit POL_REPLACE = (OFLOW == "REPLACE");
    localparam bit POL_IGNORE  = (OFLOW == "IGNORE");

    logic [WIDTH-1:0] mem [NELEM];
    logic [DEPTH-1:0] wpos;
    logic [DEPTH-1:0] rpos;
    logic             do_push;
    logic             do_pop;
    logic             do_replace;

    assign empty     = (wpos == rpos);
    assign full      = ((wpos + DEPTH'(1)) == rpos);
    assign level     = wpos - rpos;
    assign overflow  = wstore & full & ~rread;
    assign underflow = rread & empty;
    assign cfg_err   = !(POL_REPLACE || POL_IGNORE);

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop     = rread & ~empty;
    assign do_push    = wstore & (~full | rread);
    assign do_replace = overflow & POL_REPLACE;

    assign rdata = mem[rpos];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wpos <= '0;
            rpos <= '0;
        end else begin
            if (do_push) wpos <= wpos + DEPTH'(1);
            if (do_pop)  rpos <= rpos + DEPTH'(1);
        end
    end

    // Storage is deliberately not reset; REPLACE rewrites the newest entry in place.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wpos] <= wdata;
        else if (do_replace)
            mem[wpos - DEPTH'(1)] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            oflow_err <= 1'b0;
        else if (overflow)
            oflow_err <= 1'b1;
    end

`ifdef OFLOW_VALUE_NOT_VALID_STATS_EN
    logic [CNTW-1:0] ocnt_q;
    logic [CNTW-1:0] ucnt_q;

    // Both counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ocnt_q <= '0;
            ucnt_q <= '0;
        end else begin
            if (overflow && (ocnt_q != {CNTW{1'b1}}))  ocnt_q <= ocnt_q + CNTW'(1);
            if (underflow && (ucnt_q != {CNTW{1'b1}})) ucnt_q <= ucnt_q + CNTW'(1);
        end
    end

    assign oflow_cnt = ocnt_q;
    assign uflow_cnt = ucnt_q;
`else
    assign oflow_cnt = '0;
    assign uflow_cnt = '0;
`endif

endmodule

// File: tb/tb_oflow_value_not_valid.sv
// Scoreboard bench: three FIFOs (REPLACE, IGNORE, invalid policy) share stimulus and are
// checked every cycle against queue-based models of the FIFO behaviour.
module tb_oflow_value_not_valid;

    localparam int CAP = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] wdata = '0;
    logic       wstore = 1'b0;
    logic       rread = 1'b0;

    logic [7:0] rdata [3];
    logic       empty [3];
    logic       full [3];
    logic       overflow [3];
    logic       underflow [3];
    logic [1:0] level [3];
    logic       oflow_err [3];
    logic       cfg_err [3];
    logic [7:0] oflow_cnt [3];
    logic [7:0] uflow_cnt [3];

    typedef struct {
        bit         chk;
        logic [7:0] data;
        bit         empty;
        bit         full;
        bit         ovf;
        bit         unf;
        bit         oerr;
        logic [1:0] level;
        int         ocnt;
        int         ucnt;
    } exp_t;

    exp_t       sb [3][$];
    logic [7:0] mq [3][$];
    bit         m_oerr [3];
    int         m_ocnt [3];
    int         m_ucnt [3];
    bit         is_replace [3] = '{1'b1, 1'b0, 1'b0};

    int nvec = 0;
    int nmiss = 0;

    always #5 clk = ~clk;

    oflow_value_not_valid #(.OFLOW("REPLACE"), .WIDTH(8), .DEPTH(2), .CNTW(8)) dut_replace (
        .clk(clk), .reset(reset), .wdata(wdata), .wstore(wstore), .rread(rread),
        .rdata(rdata[0]), .empty(empty[0]), .full(full[0]), .overflow(overflow[0]),
        .underflow(underflow[0]), .level(level[0]), .oflow_err(oflow_err[0]),
        .cfg_err(cfg_err[0]), .oflow_cnt(oflow_cnt[0]), .uflow_cnt(uflow_cnt[0])
    );

    oflow_value_not_valid #(.OFLOW("IGNORE"), .WIDTH(8), .DEPTH(2), .CNTW(8)) dut_ignore (
        .clk(clk), .reset(reset), .wdata(wdata), .wstore(wstore), .rread(rread),
        .rdata(rdata[1]), .empty(empty[1]), .full(full[1]), .overflow(overflow[1]),
        .underflow(underflow[1]), .level(level[1]), .oflow_err(oflow_err[1]),
        .cfg_err(cfg_err[1]), .oflow_cnt(oflow_cnt[1]), .uflow_cnt(uflow_cnt[1])
    );

    oflow_value_not_valid #(.OFLOW("BOGUS"), .WIDTH(8), .DEPTH(2), .CNTW(8)) dut_bogus (
        .clk(clk), .reset(reset), .wdata(wdata), .wstore(wstore), .rread(rread),
        .rdata(rdata[2]), .empty(empty[2]), .full(full[2]), .overflow(overflow[2]),
        .underflow(underflow[2]), .level(level[2]), .oflow_err(oflow_err[2]),
        .cfg_err(cfg_err[2]), .oflow_cnt(oflow_cnt[2]), .uflow_cnt(uflow_cnt[2])
    );

    task automatic check_output(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmiss++;
            $display("[TB] FAIL %s inst%0d @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Expected values come from the model queue; each cycle is checked before its clock edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (sb[k].size() > 0) begin
                    e = sb[k].pop_front();
                    check_output("empty", k, 32'(empty[k]), 32'(e.empty));
                    check_output("full", k, 32'(full[k]), 32'(e.full));
                    check_output("level", k, 32'(level[k]), 32'(e.level));
                    check_output("overflow", k, 32'(overflow[k]), 32'(e.ovf));
                    check_output("underflow", k, 32'(underflow[k]), 32'(e.unf));
                    check_output("oflow_err", k, 32'(oflow_err[k]), 32'(e.oerr));
                    check_output("oflow_cnt", k, 32'(oflow_cnt[k]), 32'(e.ocnt));
                    check_output("uflow_cnt", k, 32'(uflow_cnt[k]), 32'(e.ucnt));
                    if (e.chk)
                        check_output("rdata", k, 32'(rdata[k]), 32'(e.data));
                end
            end
        end
    end

    // Drive one cycle, record what each FIFO should show during it, then advance the models.
    task automatic apply_stimulus(input bit ws, input logic [7:0] wd, input bit rr);
        exp_t e;
        int   n;
        wstore = ws;
        wdata  = wd;
        rread  = rr;
        for (int k = 0; k < 3; k++) begin
            n       = mq[k].size();
            e.empty = (n == 0);
            e.full  = (n == CAP);
            e.level = 2'(n);
            e.ovf   = ws && (n == CAP) && !rr;
            e.unf   = rr && (n == 0);
            e.oerr  = m_oerr[k];
            e.chk   = (n != 0);
            e.data  = (n != 0) ? mq[k][0] : 8'h00;
`ifdef OFLOW_VALUE_NOT_VALID_STATS_EN
            e.ocnt  = m_ocnt[k];
            e.ucnt  = m_ucnt[k];
`else
            e.ocnt  = 0;
            e.ucnt  = 0;
`endif
            sb[k].push_back(e);

            if (rr && n > 0) void'(mq[k].pop_front());
            if (ws) begin
                if (n < CAP || rr)
                    mq[k].push_back(wd);
                else if (is_replace[k])
                    mq[k][n-1] = wd;
            end
            if (e.ovf) m_oerr[k] = 1'b1;
            if (e.ovf && m_ocnt[k] < 255) m_ocnt[k]++;
            if (e.unf && m_ucnt[k] < 255) m_ucnt[k]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int k = 0; k < 3; k++) begin
            mq[k].delete();
            m_oerr[k] = 1'b0;
            m_ocnt[k] = 0;
            m_ucnt[k] = 0;
        end
    endtask

    task automatic drain(input int cnt);
        for (int i = 0; i < cnt; i++) apply_stimulus(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        clear_models();
        #12;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("cfg_err", 0, 32'(cfg_err[0]), 32'd0);
        check_output("cfg_err", 1, 32'(cfg_err[1]), 32'd0);
        check_output("cfg_err", 2, 32'(cfg_err[2]), 32'd1);

        apply_stimulus(1'b0, 8'h00, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0);

        apply_stimulus(1'b1, 8'h11, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0);
        apply_stimulus(1'b1, 8'h44, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        drain(3);
        drain(2);

        apply_stimulus(1'b1, 8'h11, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0);
        apply_stimulus(1'b1, 8'h55, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        drain(3);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < CAP; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0);
            drain(CAP);
        end

        for (int i = 0; i < 400; i++)
            apply_stimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
        for (int i = 0; i < 300; i++)
            apply_stimulus($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);

        for (int i = 0; i < 262; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0);
        drain(6);
        for (int i = 0; i < 258; i++) apply_stimulus(1'b0, 8'h00, 1'b1);

        apply_stimulus(1'b1, 8'hA1, 1'b0);
        apply_stimulus(1'b1, 8'hA2, 1'b0);
        reset  = 1'b0;
        wstore = 1'b0;
        rread  = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_output("async_empty", k, 32'(empty[k]), 32'd1);
            check_output("async_level", k, 32'(level[k]), 32'd0);
            check_output("async_oerr", k, 32'(oflow_err[k]), 32'd0);
        end
        clear_models();
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 200; i++)
            apply_stimulus($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
        drain(4);

        for (int k = 0; k < 3; k++)
            check_output("sb_drained", k, 32'(sb[k].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
